// File: rtl/alu_uart_sequencer.sv
// Byte-stream command sequencer between the UART rx/tx blocks and the 8-bit ALU.
// Loads A, B and OP into the ALU, then returns RESULT and FLAGS bytes.
module alu_uart_sequencer #(
    parameter int                 NB_DATA        = 8,
    parameter int                 NB_OP          = 6,
    parameter int                 TIMEOUT_CYCLES = 1_000_000,
    parameter logic [NB_DATA-1:0] ERR_CODE       = 8'hEE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_DATA-1:0] o_alu_data,
    output logic               o_en_a,
    output logic               o_en_b,
    output logic               o_en_op,
    input  logic [NB_DATA-1:0] i_alu_data,
    input  logic               i_alu_carry,
    input  logic               i_alu_zero,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_timeout,
    output logic               o_overrun
);

    localparam int                NB_CNT  = $clog2(TIMEOUT_CYCLES);
    localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        WAIT_A, WAIT_B, WAIT_OP, LOAD, CAPTURE,
        TX_RES, WAIT_RES, TX_FLG, WAIT_FLG, TX_ERR, WAIT_ERR
    } state_t;

    state_t             state, state_nx;
    logic [NB_DATA-1:0] res, res_nx;
    logic [NB_DATA-1:0] flg, flg_nx;
    logic [NB_DATA-1:0] alu_data_nx, tx_data_nx;
    logic [NB_CNT-1:0]  cnt, cnt_nx;
    logic               en_a_nx, en_b_nx, en_op_nx;
    logic               tx_start_nx, timeout_nx, overrun_nx;
    logic               op_ok;

    always_comb begin
        op_ok = 1'b0;
        if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
            case (i_rx_data[NB_OP-1:0])
                6'h20, 6'h22, 6'h24, 6'h25,
                6'h26, 6'h27, 6'h02, 6'h03: op_ok = 1'b1;
                default:                    op_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        res_nx      = res;
        flg_nx      = flg;
        cnt_nx      = cnt;
        alu_data_nx = o_alu_data;
        tx_data_nx  = o_tx_data;
        en_a_nx     = 1'b0;
        en_b_nx     = 1'b0;
        en_op_nx    = 1'b0;
        tx_start_nx = 1'b0;
        timeout_nx  = 1'b0;
        overrun_nx  = 1'b0;
        case (state)
            WAIT_A: if (i_rx_valid) begin
                alu_data_nx = i_rx_data;
                en_a_nx     = 1'b1;
                cnt_nx      = '0;
                state_nx    = WAIT_B;
            end
            WAIT_B: if (i_rx_valid) begin
                alu_data_nx = i_rx_data;
                en_b_nx     = 1'b1;
                cnt_nx      = '0;
                state_nx    = WAIT_OP;
            end else if (cnt == CNT_MAX) begin
                timeout_nx = 1'b1;
                state_nx   = WAIT_A;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            WAIT_OP: if (i_rx_valid) begin
                cnt_nx = '0;
                if (op_ok) begin
                    alu_data_nx = {i_rx_data[NB_OP-1:0], 2'b00};
                    en_op_nx    = 1'b1;
                    state_nx    = LOAD;
                end else begin
                    state_nx = TX_ERR;
                end
            end else if (cnt == CNT_MAX) begin
                timeout_nx = 1'b1;
                state_nx   = WAIT_A;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            LOAD:     state_nx = CAPTURE;
            CAPTURE: begin
                res_nx   = i_alu_data;
                flg_nx   = {{(NB_DATA-2){1'b0}}, i_alu_carry, i_alu_zero};
                state_nx = TX_RES;
            end
            TX_RES: begin
                tx_data_nx  = res;
                tx_start_nx = 1'b1;
                state_nx    = WAIT_RES;
            end
            WAIT_RES: if (i_tx_done) state_nx = TX_FLG;
            TX_FLG: begin
                tx_data_nx  = flg;
                tx_start_nx = 1'b1;
                state_nx    = WAIT_FLG;
            end
            WAIT_FLG: if (i_tx_done) state_nx = WAIT_A;
            TX_ERR: begin
                tx_data_nx  = ERR_CODE;
                tx_start_nx = 1'b1;
                state_nx    = WAIT_ERR;
            end
            WAIT_ERR: if (i_tx_done) state_nx = WAIT_A;
            default:  state_nx = WAIT_A;
        endcase
        // Bytes arriving while a command is executing are dropped
        if (i_rx_valid && !(state inside {WAIT_A, WAIT_B, WAIT_OP}))
            overrun_nx = 1'b1;
        if (state_nx == WAIT_A)
            cnt_nx = '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= WAIT_A;
            res        <= '0;
            flg        <= '0;
            cnt        <= '0;
            o_alu_data <= '0;
            o_en_a     <= 1'b0;
            o_en_b     <= 1'b0;
            o_en_op    <= 1'b0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_nx;
            res        <= res_nx;
            flg        <= flg_nx;
            cnt        <= cnt_nx;
            o_alu_data <= alu_data_nx;
            o_en_a     <= en_a_nx;
            o_en_b     <= en_b_nx;
            o_en_op    <= en_op_nx;
            o_tx_data  <= tx_data_nx;
            o_tx_start <= tx_start_nx;
            o_busy     <= (state_nx != WAIT_A);
            o_timeout  <= timeout_nx;
            o_overrun  <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with an ALU model, a transmitter
// model and a scoreboard of expected tx bytes.
module tb_alu_uart_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_alu_data;
    logic       o_en_a, o_en_b, o_en_op;
    logic [7:0] i_alu_data;
    logic       i_alu_carry, i_alu_zero;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       i_tx_done;
    logic       o_busy, o_timeout, o_overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [9:0] strb_q[$];

    alu_uart_sequencer #(
        .NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16), .ERR_CODE(8'hEE)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_alu_data(o_alu_data), .o_en_a(o_en_a), .o_en_b(o_en_b), .o_en_op(o_en_op),
        .i_alu_data(i_alu_data), .i_alu_carry(i_alu_carry), .i_alu_zero(i_alu_zero),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_timeout(o_timeout), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ALU model: latches on strobes, op field is data[7:2]
    logic [7:0] alu_a = 8'h00, alu_b = 8'h00;
    logic [5:0] alu_op = 6'h00;
    logic [8:0] alu_t;

    always @(posedge i_clk) begin
        if (o_en_a)  alu_a  <= o_alu_data;
        if (o_en_b)  alu_b  <= o_alu_data;
        if (o_en_op) alu_op <= o_alu_data[7:2];
    end

    always_comb begin
        alu_t = 9'h000;
        case (alu_op)
            6'h20:   alu_t = {1'b0, alu_a} + {1'b0, alu_b};
            6'h22:   alu_t = {1'b0, alu_a} - {1'b0, alu_b};
            6'h24:   alu_t = {1'b0, alu_a & alu_b};
            6'h25:   alu_t = {1'b0, alu_a | alu_b};
            6'h26:   alu_t = {1'b0, alu_a ^ alu_b};
            6'h27:   alu_t = {1'b0, $signed(alu_a) >>> alu_b[2:0]};
            6'h02:   alu_t = {1'b0, alu_a >> alu_b[2:0]};
            6'h03:   alu_t = {1'b0, ~(alu_a | alu_b)};
            default: alu_t = 9'h000;
        endcase
        i_alu_data  = alu_t[7:0];
        i_alu_carry = alu_t[8];
        i_alu_zero  = (alu_t[7:0] == 8'h00);
    end

    // Strobe monitor: logs every ALU load and checks one-hot strobes
    always @(negedge i_clk) begin
        if (o_en_a | o_en_b | o_en_op) begin
            chk("strobe_onehot", 32'($countones({o_en_a, o_en_b, o_en_op})), 1);
            strb_q.push_back({o_en_op ? 2'd3 : (o_en_b ? 2'd2 : 2'd1), o_alu_data});
        end
    end

    // Transmitter model: 2-cycle byte time, checks against the scoreboard
    initial begin
        logic [7:0] e;
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_tx_start) begin
                repeat (2) @(negedge i_clk);
                chk("tx_expected", 32'(exp_q.size() != 0), 1);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                chk("tx_byte", 32'(o_tx_data), 32'(e));
                i_tx_done = 1'b1;
                @(negedge i_clk);
                i_tx_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!o_busy && exp_q.size() == 0) break;
            @(negedge i_clk);
        end
        chk(tag, {30'd0, o_busy, exp_q.size() != 0}, 0);
    endtask

    function automatic logic [31:0] all_outs();
        return {o_alu_data, o_tx_data, o_en_a, o_en_b, o_en_op,
                o_tx_start, o_busy, o_timeout, o_overrun};
    endfunction

    initial begin
        int n;
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (3) @(negedge i_clk);
        chk("reset_outputs", all_outs(), 0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // 1: ADD 05+03
        strb_q.delete();
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        send3(8'h05, 8'h03, 8'h20);
        wait_idle("idle_add");
        chk("strb_count", strb_q.size(), 3);
        chk("strb_a", 32'(strb_q[0]), {22'd0, 2'd1, 8'h05});
        chk("strb_b", 32'(strb_q[1]), {22'd0, 2'd2, 8'h03});
        chk("strb_op", 32'(strb_q[2]), {22'd0, 2'd3, 8'h80});

        // 2: ADD with carry, SUB with borrow
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h03);
        send3(8'hFF, 8'h01, 8'h20);
        wait_idle("idle_add_carry");
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'h02);
        send3(8'h03, 8'h05, 8'h22);
        wait_idle("idle_sub");

        // 3: invalid opcode
        strb_q.delete();
        exp_q.push_back(8'hEE);
        send3(8'h01, 8'h02, 8'h15);
        wait_idle("idle_err");
        chk("err_strb_count", strb_q.size(), 2);
        chk("err_busy", 32'(o_busy), 0);

        // 4a: timeout after 16 silent cycles
        send_byte(8'h11);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            n++;
            if (o_timeout) break;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_busy", 32'(o_busy), 0);
        @(negedge i_clk);
        chk("timeout_pulse", 32'(o_timeout), 0);

        // 4b: byte lands on the expiry cycle
        send_byte(8'h11);
        repeat (15) @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h22;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        chk("expiry_accept", {30'd0, o_timeout, o_en_b}, 1);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h00);
        send_byte(8'h20);
        wait_idle("idle_expiry");

        // 5a: overrun while waiting for tx done
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send3(8'h0F, 8'hF0, 8'h25);
        for (int i = 0; i < 20; i++) begin
            if (o_tx_start) break;
            @(negedge i_clk);
        end
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h5A;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        chk("overrun_pulse", 32'(o_overrun), 1);
        wait_idle("idle_overrun");

        // 5b: back-to-back commands
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h03);
        send3(8'hAA, 8'h55, 8'h26);
        for (int i = 0; i < 40; i++) begin
            if (!o_busy) break;
            @(negedge i_clk);
        end
        send3(8'h80, 8'h80, 8'h20);
        wait_idle("idle_b2b");

        // 6a: reset in WAIT_OP
        send_byte(8'h07);
        send_byte(8'h02);
        i_reset = 1'b1;
        #1;
        chk("reset_wait_op", all_outs(), 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h00);
        send3(8'h07, 8'h02, 8'h22);
        wait_idle("idle_after_rst1");

        // 6b: reset in TX_FLG
        exp_q.push_back(8'h30);
        send3(8'h10, 8'h20, 8'h20);
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk);
            if (i_tx_done) break;
        end
        #1;
        i_reset = 1'b1;
        #1;
        chk("reset_tx_flg", all_outs(), 0);
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        send3(8'h02, 8'h02, 8'h22);
        wait_idle("idle_after_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
